io_output_sequencer: RTL and testbench

- Parametrised output sequencer for the I/O electronics.
- On one load pulse it captures a signed word and converts it to a character stream: sign char, MAG_W-bit magnitude as octal or decimal digit chars MSB-first, then an end char.
- Characters are buffered in a DEPTH-entry FIFO and drained to the output device by a 4-phase rdy/ack handshake, so the arithmetic unit is released immediately.
- On completion it can restart the control unit via a start pulse.

---
 rtl/io_output_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_io_output_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_output_sequencer.sv
// Output sequencer: a loaded signed word becomes a sign / digit / end character stream,
// buffered in a small FIFO and drained over a 4-phase rdy/ack handshake.
// Optional build macro IO_OUT_ZERO_SUPPRESS_EN drops leading zero digits.
module io_output_sequencer #(
  parameter int MAG_W = 30,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_pulse_from_op,
  input  logic             load_sign_from_ac,
  input  logic [MAG_W-1:0] load_mag_from_au,
  input  logic             output_oct_from_pnl,
  input  logic             stop_after_output_from_pnl,
  input  logic             abort_from_pnl,
  output logic             busy_to_op,
  output logic             overrun_err,
  output logic             done_pulse,
  output logic             start_pulse_to_pu,
  output logic             output_rdy_to_dev,
  input  logic             output_ack_from_dev,
  output logic [4:0]       output_data_to_dev
);

  localparam int ND_OCT = (MAG_W + 2) / 3;
  localparam int ND_DEC = (MAG_W + 3) / 4;
  localparam int EXT_W  = (ND_OCT * 3 > ND_DEC * 4) ? ND_OCT * 3 : ND_DEC * 4;
  localparam int CNT_W  = $clog2(ND_OCT + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [4:0] END_CHAR = 5'b00110;

  typedef enum logic [1:0] {P_IDLE = 2'd0, P_SIGN = 2'd1, P_DIG = 2'd2, P_END = 2'd3} p_state_t;
  typedef enum logic [1:0] {C_IDLE = 2'd0, C_RDY = 2'd1, C_ACK = 2'd2} c_state_t;

  // Digit idx counts from the most significant group of the zero-extended magnitude.
  function automatic logic [4:0] digit_char(input logic [EXT_W-1:0] mag, input logic oct,
                                            input logic [CNT_W-1:0] idx);
    int grp;
    if (oct) begin
      grp        = ND_OCT - 1 - int'(idx);
      digit_char = {2'b10, 3'(mag >> (3 * grp))};
    end else begin
      grp        = ND_DEC - 1 - int'(idx);
      digit_char = {1'b1, 4'(mag >> (4 * grp))};
    end
  endfunction

  logic             sign_q, sign_d, oct_q, oct_d;
  logic [EXT_W-1:0] mag_q, mag_d;
  logic             busy_q, busy_d, overrun_q, overrun_d, abort_pend_q, abort_pend_d;
  p_state_t         p_state_q, p_state_d;
  c_state_t         c_state_q, c_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d, done_q, done_d, start_q, start_d;
  logic [4:0]       data_q, data_d;
  logic [4:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             load_accept_s, flush_s, full_s, empty_s, space_s;
  logic             push_req_s, push_s, pop_s, skip_s, done_evt_s;
  logic [4:0]       push_char_s, dig_char_s;
  logic [CNT_W-1:0] last_idx_s;
`ifdef IO_OUT_ZERO_SUPPRESS_EN
  logic             lead_q, lead_d;
`endif

  always_comb begin
    load_accept_s = load_pulse_from_op & ~busy_q & ~abort_from_pnl;
    flush_s       = abort_from_pnl;
    full_s        = (count_q == (PTR_W + 1)'(DEPTH));
    empty_s       = (count_q == {(PTR_W + 1){1'b0}});
    space_s       = ~full_s | pop_s;
    last_idx_s    = oct_q ? CNT_W'(ND_OCT - 1) : CNT_W'(ND_DEC - 1);
    dig_char_s    = digit_char(mag_q, oct_q, cnt_q);
    if (load_accept_s) begin
      sign_d = load_sign_from_ac;
      mag_d  = EXT_W'(load_mag_from_au);
      oct_d  = output_oct_from_pnl;
    end else begin
      sign_d = sign_q;
      mag_d  = mag_q;
      oct_d  = oct_q;
    end
  end

  // Producer next state: one character per cycle, stalled while the FIFO has no room.
  always_comb begin
    p_state_d   = p_state_q;
    cnt_d       = cnt_q;
    push_req_s  = 1'b0;
    push_char_s = 5'b00000;
`ifdef IO_OUT_ZERO_SUPPRESS_EN
    skip_s = lead_q & (dig_char_s == 5'h10) & (cnt_q != last_idx_s);
`else
    skip_s = 1'b0;
`endif
    if (flush_s) begin
      p_state_d = P_IDLE;
    end else begin
      case (p_state_q)
        P_IDLE: begin
          if (load_accept_s) begin
            p_state_d = P_SIGN;
            cnt_d     = {CNT_W{1'b0}};
          end else begin
            p_state_d = P_IDLE;
          end
        end
        P_SIGN: begin
          push_req_s  = 1'b1;
          push_char_s = {4'b1111, sign_q};
          if (space_s) p_state_d = P_DIG;
          else         p_state_d = P_SIGN;
        end
        P_DIG: begin
          push_char_s = dig_char_s;
          if (skip_s) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            push_req_s = 1'b1;
            if (space_s && (cnt_q == last_idx_s)) p_state_d = P_END;
            else if (space_s)                     cnt_d = cnt_q + CNT_W'(1);
            else                                  cnt_d = cnt_q;
          end
        end
        P_END: begin
          push_req_s  = 1'b1;
          push_char_s = END_CHAR;
          if (space_s) p_state_d = P_IDLE;
          else         p_state_d = P_END;
        end
        default: p_state_d = P_IDLE;
      endcase
    end
    push_s = push_req_s & space_s;
  end

`ifdef IO_OUT_ZERO_SUPPRESS_EN
  always_comb begin
    if (load_accept_s)                        lead_d = 1'b1;
    else if ((p_state_q == P_DIG) && push_s)  lead_d = 1'b0;
    else                                      lead_d = lead_q;
  end
`endif

  // Consumer next state; an abort during C_ACK still waits for the device to drop ack.
  always_comb begin
    c_state_d = c_state_q;
    pop_s     = 1'b0;
    case (c_state_q)
      C_IDLE: begin
        if (!empty_s && !flush_s) c_state_d = C_RDY;
        else                      c_state_d = C_IDLE;
      end
      C_RDY: begin
        if (flush_s)                  c_state_d = C_IDLE;
        else if (output_ack_from_dev) c_state_d = C_ACK;
        else                          c_state_d = C_RDY;
      end
      C_ACK: begin
        if (!output_ack_from_dev) begin
          c_state_d = C_IDLE;
          pop_s     = ~flush_s & ~abort_pend_q;
        end else begin
          c_state_d = C_ACK;
        end
      end
      default: c_state_d = C_IDLE;
    endcase
    done_evt_s = pop_s & (data_q == END_CHAR);
  end

  always_comb begin
    rdy_d = (c_state_d == C_RDY);
    if (c_state_d == C_IDLE)      data_d = 5'b00000;
    else if (c_state_q == C_IDLE) data_d = mem_q[rptr_q];
    else                          data_d = data_q;
    done_d  = done_evt_s;
    start_d = done_q & ~stop_after_output_from_pnl;
  end

  always_comb begin
    if (flush_s) begin
      wptr_d  = {PTR_W{1'b0}};
      rptr_d  = {PTR_W{1'b0}};
      count_d = {(PTR_W + 1){1'b0}};
    end else begin
      wptr_d  = wptr_q + PTR_W'(push_s);
      rptr_d  = rptr_q + PTR_W'(pop_s);
      count_d = count_q + (PTR_W + 1)'(push_s) - (PTR_W + 1)'(pop_s);
    end
    if (load_accept_s)                                          busy_d = 1'b1;
    else if (done_evt_s)                                        busy_d = 1'b0;
    else if (((flush_s & busy_q) | abort_pend_q) && (c_state_d == C_IDLE)) busy_d = 1'b0;
    else                                                        busy_d = busy_q;
    if (flush_s && busy_q && (c_state_d != C_IDLE)) abort_pend_d = 1'b1;
    else if (c_state_d == C_IDLE)                   abort_pend_d = 1'b0;
    else                                            abort_pend_d = abort_pend_q;
    overrun_d = overrun_q | (load_pulse_from_op & busy_q & ~abort_from_pnl);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sign_q <= 1'b0;  oct_q <= 1'b0;  mag_q <= {EXT_W{1'b0}};
      busy_q <= 1'b0;  overrun_q <= 1'b0;  abort_pend_q <= 1'b0;
      p_state_q <= P_IDLE;  c_state_q <= C_IDLE;  cnt_q <= {CNT_W{1'b0}};
      rdy_q <= 1'b0;  done_q <= 1'b0;  start_q <= 1'b0;  data_q <= 5'b00000;
      wptr_q <= {PTR_W{1'b0}};  rptr_q <= {PTR_W{1'b0}};  count_q <= {(PTR_W + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 5'b00000;
`ifdef IO_OUT_ZERO_SUPPRESS_EN
      lead_q <= 1'b0;
`endif
    end else begin
      sign_q <= sign_d;  oct_q <= oct_d;  mag_q <= mag_d;
      busy_q <= busy_d;  overrun_q <= overrun_d;  abort_pend_q <= abort_pend_d;
      p_state_q <= p_state_d;  c_state_q <= c_state_d;  cnt_q <= cnt_d;
      rdy_q <= rdy_d;  done_q <= done_d;  start_q <= start_d;  data_q <= data_d;
      wptr_q <= wptr_d;  rptr_q <= rptr_d;  count_q <= count_d;
      if (push_s) mem_q[wptr_q] <= push_char_s;
`ifdef IO_OUT_ZERO_SUPPRESS_EN
      lead_q <= lead_d;
`endif
    end
  end

  assign busy_to_op         = busy_q;
  assign overrun_err        = overrun_q;
  assign done_pulse         = done_q;
  assign start_pulse_to_pu  = start_q;
  assign output_rdy_to_dev  = rdy_q;
  assign output_data_to_dev = data_q;

endmodule

// File: tb/tb_io_output_sequencer.sv
// Scoreboard bench for io_output_sequencer: directed loads push hand-computed character
// streams; a monitor pops one expectation per character presented on the handshake.
module tb_io_output_sequencer;
  localparam int MAG_W = 30;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic resetn, load_pulse, load_sign, oct, stop, abort, ack;
  logic [MAG_W-1:0] load_mag;
  logic busy, overrun, done, start, rdy;
  logic [4:0] data;

  io_output_sequencer #(.MAG_W(MAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .load_pulse_from_op(load_pulse),
    .load_sign_from_ac(load_sign), .load_mag_from_au(load_mag),
    .output_oct_from_pnl(oct), .stop_after_output_from_pnl(stop),
    .abort_from_pnl(abort), .busy_to_op(busy), .overrun_err(overrun),
    .done_pulse(done), .start_pulse_to_pu(start), .output_rdy_to_dev(rdy),
    .output_ack_from_dev(ack), .output_data_to_dev(data)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [4:0] exp_q[$];
  logic [4:0] cur_exp;
  bit cur_valid = 0, prev_rdy = 0, prev_done = 0, stop_at_done = 0;
  int done_cnt = 0, start_cnt = 0, presented = 0;
  int ack_delay = 1, ack_hold = 0;
  int d0, s0, p0, k;
  bit seen;

  logic [4:0] v_oct [12] = '{5'h1F, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h10, 5'h11, 5'h12, 5'h06};
  logic [4:0] v_dec [10] = '{5'h1E, 5'h10, 5'h10, 5'h19, 5'h18, 5'h17, 5'h16, 5'h15, 5'h14, 5'h06};
  logic [4:0] v_stl [10] = '{5'h1F, 5'h10, 5'h13, 5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F, 5'h06};
  logic [4:0] v_max [10] = '{5'h1E, 5'h13, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h06};
  logic [4:0] v_ovr [12] = '{5'h1E, 5'h17, 5'h16, 5'h15, 5'h14, 5'h13, 5'h12, 5'h11, 5'h10, 5'h17, 5'h16, 5'h06};
`ifdef IO_OUT_ZERO_SUPPRESS_EN
  logic [4:0] v_z5 [3] = '{5'h1E, 5'h15, 5'h06};
  logic [4:0] v_z0 [3] = '{5'h1E, 5'h10, 5'h06};
`else
  logic [4:0] v_z5 [12] = '{5'h1E, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h15, 5'h06};
  logic [4:0] v_z0 [12] = '{5'h1E, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h06};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Device model: raise ack ack_delay cycles after rdy, drop it ack_hold cycles after rdy falls.
  int dev_cnt = 0;
  initial begin
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        ack = 1'b0; dev_cnt = 0;
      end else if (!ack) begin
        if (rdy) begin
          if (dev_cnt >= ack_delay) begin ack = 1'b1; dev_cnt = 0; end
          else dev_cnt++;
        end
      end else if (!rdy) begin
        if (dev_cnt >= ack_hold) begin ack = 1'b0; dev_cnt = 0; end
        else dev_cnt++;
      end
    end
  end

  // Monitor: one expectation per presented character, data held while rdy, start after done.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (rdy && !prev_rdy) begin
          presented++;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++; cur_valid = 0;
            $display("FAIL unexpected_char: got %0h, expected none", data);
          end else begin
            cur_exp = exp_q.pop_front(); cur_valid = 1;
            check("char", data, cur_exp);
          end
        end else if (rdy && cur_valid) begin
          check("char_stable", data, cur_exp);
        end
        if (prev_done) check("start_after_done", start, !stop_at_done);
        else           check("no_spurious_start", start, 0);
        if (done) begin done_cnt++; stop_at_done = stop; end
        if (start) start_cnt++;
        prev_rdy = rdy; prev_done = done;
      end else begin
        prev_rdy = 0; prev_done = 0; cur_valid = 0;
      end
    end
  end

  task automatic run_load(input bit s, input logic [MAG_W-1:0] m, input bit o);
    @(negedge clk);
    load_sign = s; load_mag = m; oct = o; load_pulse = 1'b1;
    @(negedge clk);
    load_pulse = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic end_checks(input string name, input int exp_done, input int exp_start);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_done_cnt"}, done_cnt - d0, exp_done);
    check({name, "_start_cnt"}, start_cnt - s0, exp_start);
    check({name, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0; load_pulse = 0; load_sign = 0; load_mag = '0; oct = 0; stop = 0; abort = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);   check("rst_overrun", overrun, 0);
    check("rst_done", done, 0);   check("rst_start", start, 0);
    check("rst_rdy", rdy, 0);     check("rst_data", data, 0);
    resetn = 1;
    @(negedge clk);

    // Octal stream with restart request.
    d0 = done_cnt; s0 = start_cnt; ack_delay = 1;
    foreach (v_oct[i]) exp_q.push_back(v_oct[i]);
    run_load(1'b1, 30'o1234567012, 1'b1);
    check("oct_busy_after_load", busy, 1);
    wait_idle("oct", 2000);
    end_checks("oct", 1, 1);

    // Decimal stream, stop suppresses the restart.
    d0 = done_cnt; s0 = start_cnt; ack_delay = 3; stop = 1;
    foreach (v_dec[i]) exp_q.push_back(v_dec[i]);
    run_load(1'b0, 30'h0987654, 1'b0);
    wait_idle("dec", 2000);
    end_checks("dec", 1, 0);
    stop = 0;

    // Slow device: producer stalls on the full FIFO.
    d0 = done_cnt; s0 = start_cnt; ack_delay = 50;
    foreach (v_stl[i]) exp_q.push_back(v_stl[i]);
    run_load(1'b1, 30'h3ABCDEF, 1'b0);
    wait_idle("stall", 3000);
    end_checks("stall", 1, 1);

    // Full-scale decimal with mode flipped mid-sequence.
    d0 = done_cnt; s0 = start_cnt; ack_delay = 0;
    foreach (v_max[i]) exp_q.push_back(v_max[i]);
    run_load(1'b0, 30'h3FFFFFFF, 1'b0);
    repeat (4) @(negedge clk);
    oct = 1'b1;
    wait_idle("max", 2000);
    end_checks("max", 1, 1);

    // Second load while busy is ignored and flags overrun.
    d0 = done_cnt; s0 = start_cnt; ack_delay = 1;
    foreach (v_ovr[i]) exp_q.push_back(v_ovr[i]);
    run_load(1'b0, 30'o7654321076, 1'b1);
    repeat (5) @(negedge clk);
    run_load(1'b1, 30'o1111111111, 1'b0);
    check("overrun_set", overrun, 1);
    wait_idle("ovr", 2000);
    end_checks("ovr", 1, 1);
    check("overrun_sticky", overrun, 1);

    // Abort while the device holds ack on digit 3.
    d0 = done_cnt; s0 = start_cnt; ack_delay = 1; ack_hold = 6; p0 = presented;
    foreach (v_oct[i]) exp_q.push_back(v_oct[i]);
    run_load(1'b1, 30'o1234567012, 1'b1);
    k = 0;
    while (!((presented - p0 == 5) && ack && !rdy) && k < 1000) begin @(negedge clk); k++; end
    check("abort_reached_digit3", presented - p0, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_q.delete();
    check("abort_busy_while_ack", busy, 1);
    wait_idle("abort", 200);
    check("abort_ack_low", ack, 0);
    seen = 0;
    repeat (10) begin @(negedge clk); if (rdy) seen = 1; end
    check("abort_no_rdy", seen, 0);
    end_checks("abort", 0, 0);
    ack_hold = 0;

    // Fresh load after abort yields a complete stream.
    d0 = done_cnt; s0 = start_cnt;
    foreach (v_oct[i]) exp_q.push_back(v_oct[i]);
    run_load(1'b1, 30'o1234567012, 1'b1);
    wait_idle("reload", 2000);
    end_checks("reload", 1, 1);

    // Small magnitudes (leading zeros).
    d0 = done_cnt; s0 = start_cnt;
    foreach (v_z5[i]) exp_q.push_back(v_z5[i]);
    run_load(1'b0, 30'd5, 1'b1);
    wait_idle("mag5", 2000);
    end_checks("mag5", 1, 1);
    d0 = done_cnt; s0 = start_cnt;
    foreach (v_z0[i]) exp_q.push_back(v_z0[i]);
    run_load(1'b0, 30'd0, 1'b1);
    wait_idle("mag0", 2000);
    end_checks("mag0", 1, 1);

    // Reset mid-sequence drops rdy on the next edge and clears overrun.
    foreach (v_oct[i]) exp_q.push_back(v_oct[i]);
    ack_delay = 20;
    run_load(1'b1, 30'o1234567012, 1'b1);
    k = 0;
    while (!rdy && k < 100) begin @(negedge clk); k++; end
    check("rstmid_rdy_seen", rdy, 1);
    resetn = 1'b0;
    @(negedge clk);
    check("rstmid_rdy", rdy, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_overrun", overrun, 0);
    check("rstmid_data", data, 0);
    exp_q.delete();
    resetn = 1'b1;
    ack_delay = 1;
    repeat (2) @(negedge clk);

    // Load coinciding with abort is dropped without overrun.
    abort = 1'b1; load_pulse = 1'b1; load_mag = 30'd7; oct = 1'b1;
    @(negedge clk);
    abort = 1'b0; load_pulse = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_load_busy", busy, 0);
    check("abort_load_overrun", overrun, 0);
    check("abort_load_rdy", rdy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
